ppu_vram_arbiter: RTL and testbench

Shares the PPU's single-port VRAM between the render fetch pipeline inside `ppu_toplevel` and the CPU-side PPUADDR/PPUDATA ($2006/$2007) port. Render fetches always win. CPU accesses are captured, held pending and served in the first free cycle. The block owns the CPU VRAM address (t/v registers, write toggle, 1/32 auto-increment) and the $2007 read buffer. It sits between the PPU register file and the VRAM instance, on the 25 MHz pixel clock.

---
 rtl/ppu_pkg.sv | 17 +
 rtl/ppu_vaddr_reg.sv | 64 ++++++
 rtl/ppu_vram_arbiter.sv | 110 +++++++++++
 tb/tb_ppu_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter and its address register.
package ppu_pkg;

    localparam int VRAM_ADDR_W = 14;

    // Auto-increment steps applied to v after each CPU data access.
    localparam int INC_ACROSS = 1;
    localparam int INC_DOWN   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PEND = 2'd1,
        RD_PEND = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ppu_vaddr_reg.sv
// CPU-side VRAM address: temp address t, current address v, write toggle w,
// the post-access increment and the deferred v <= t load.
import ppu_pkg::*;

module ppu_vaddr_reg #(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              addr_wr,    // $2006 write strobe
    input  logic [7:0]        wdata,
    input  logic              latch_clr,  // $2002 read clears the toggle
    input  logic              hold,       // a CPU data access is captured but not issued
    input  logic              step,       // the pending access issues this cycle
    input  logic              inc32,
    output logic [ADDR_W-1:0] v
);

    logic [ADDR_W-1:0] t;
    logic              w;
    logic              load_pend;
    logic              lo_wr;
    logic [ADDR_W-1:0] t_lo_new;
    logic [ADDR_W-1:0] v_inc;

    assign lo_wr    = addr_wr & w;
    assign t_lo_new = {t[ADDR_W-1:8], wdata};
    assign v_inc    = v + (inc32 ? ADDR_W'(INC_DOWN) : ADDR_W'(INC_ACROSS));

    // Toggle, temp address and current address. A low-byte load that lands
    // while an access is still waiting is parked until that access has used
    // and incremented v, so the newly written address is what remains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t         <= '0;
            v         <= '0;
            w         <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            if (latch_clr)
                w <= 1'b0;
            else if (addr_wr)
                w <= ~w;

            if (addr_wr) begin
                if (w)
                    t[7:0] <= wdata;
                else
                    t[ADDR_W-1:8] <= wdata[ADDR_W-9:0];
            end

            if (lo_wr && (!hold || step)) begin
                v         <= t_lo_new;
                load_pend <= 1'b0;
            end else if (lo_wr) begin
                load_pend <= 1'b1;
            end else if (step) begin
                v         <= load_pend ? t : v_inc;
                load_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares the single-port VRAM between render fetches (always first) and the
// CPU $2006/$2007 port. Owns the CPU access FSM, the bus mux and the $2007
// read buffer; the CPU address lives in ppu_vaddr_reg.
import ppu_pkg::*;

module ppu_vram_arbiter #(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    output logic              render_gnt,
    output logic              render_rvalid,
    input  logic              cpu_addr_wr,
    input  logic              cpu_data_wr,
    input  logic              cpu_data_rd,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              latch_clr,
    input  logic              inc32,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    // Render handshake: render_req is a per-cycle request with no backpressure;
    // render_gnt mirrors it in the same cycle, the VRAM address is render_addr
    // in that cycle, and render_rvalid marks vram_rdata one cycle later.
    // CPU strobes are single-cycle and never stalled; a strobe arriving while
    // cpu_busy is high is dropped and recorded in overrun.

    arb_state_t        state, state_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_buf;
    logic [ADDR_W-1:0] v;
    logic              pending;
    logic              issue;

    assign pending = (state == WR_PEND) || (state == RD_PEND);
    assign issue   = pending && !render_req;

    ppu_vaddr_reg #(.ADDR_W(ADDR_W)) u_vaddr (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_wr   (cpu_addr_wr),
        .wdata     (cpu_wdata[7:0]),
        .latch_clr (latch_clr),
        .hold      (pending),
        .step      (issue),
        .inc32     (inc32),
        .v         (v)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and VRAM bus mux; render always owns the bus when it asks.
    always_comb begin
        state_nxt  = state;
        render_gnt = render_req;
        cpu_busy   = (state != IDLE);
        vram_addr  = render_req ? render_addr : v;
        vram_we    = (state == WR_PEND) && !render_req;
        vram_wdata = wdata_q;
        case (state)
            IDLE: begin
                if (cpu_data_wr)
                    state_nxt = WR_PEND;
                else if (cpu_data_rd)
                    state_nxt = RD_PEND;
            end
            WR_PEND: if (!render_req) state_nxt = IDLE;
            RD_PEND: if (!render_req) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Held write data, read buffer, sticky overrun and render read-valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdata_q       <= '0;
            rd_buf        <= '0;
            overrun       <= 1'b0;
            render_rvalid <= 1'b0;
        end else begin
            render_rvalid <= render_req;
            if (state == IDLE && cpu_data_wr)
                wdata_q <= cpu_wdata;
            if (state == RD_WAIT)
                rd_buf <= vram_rdata;
            if ((state != IDLE && (cpu_data_wr || cpu_data_rd)) ||
                (state == IDLE && cpu_data_wr && cpu_data_rd))
                overrun <= 1'b1;
        end
    end

    assign cpu_rdata = rd_buf;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: a vector table for the single-cycle
// behaviour plus hand-written read and reset sequences; a VRAM model and a
// write scoreboard run alongside.
module tb_ppu_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          render_req, render_gnt, render_rvalid;
    logic [AW-1:0] render_addr;
    logic          cpu_addr_wr, cpu_data_wr, cpu_data_rd, latch_clr, inc32;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_busy, overrun;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata, vram_rdata;

    ppu_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .render_req    (render_req),
        .render_addr   (render_addr),
        .render_gnt    (render_gnt),
        .render_rvalid (render_rvalid),
        .cpu_addr_wr   (cpu_addr_wr),
        .cpu_data_wr   (cpu_data_wr),
        .cpu_data_rd   (cpu_data_rd),
        .cpu_wdata     (cpu_wdata),
        .latch_clr     (latch_clr),
        .inc32         (inc32),
        .cpu_rdata     (cpu_rdata),
        .cpu_busy      (cpu_busy),
        .overrun       (overrun),
        .vram_addr     (vram_addr),
        .vram_we       (vram_we),
        .vram_wdata    (vram_wdata),
        .vram_rdata    (vram_rdata)
    );

    // Synchronous single-port VRAM, one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every VRAM write must be the next expected {addr,data}.
    always begin
        @(negedge clk);
        #3;
        if (vram_we) begin
            if (exp_q.size() == 0)
                chk("unexpected_write", {18'd0, vram_addr}, 32'hFFFF);
            else
                chk("write_addr_data", {10'd0, vram_addr, vram_wdata}, {10'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        cpu_addr_wr = 0; cpu_data_wr = 0; cpu_data_rd = 0; cpu_wdata = '0;
        latch_clr = 0; inc32 = 0; render_req = 0; render_addr = '0;
    endtask

    task automatic drive(input logic aw, input logic dw, input logic dr,
                         input logic [7:0] wd, input logic rq, input logic [13:0] ra);
        @(negedge clk);
        idle_inputs();
        cpu_addr_wr = aw; cpu_data_wr = dw; cpu_data_rd = dr; cpu_wdata = wd;
        render_req = rq; render_addr = ra;
        #2;
    endtask

    typedef struct {
        logic       aw, dw, dr;
        logic [7:0] wd;
        logic       lc, i32, rq;
        logic [13:0] ra;
        logic       gnt, rv, we;
        logic [13:0] addr;
        logic [7:0] wdat;
        logic       busy, ovr;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic aw, input logic dw, input logic dr, input logic [7:0] wd,
                       input logic lc, input logic i32, input logic rq, input logic [13:0] ra,
                       input logic gnt, input logic rv, input logic we, input logic [13:0] addr,
                       input logic [7:0] wdat, input logic busy, input logic ovr);
        vec_t r;
        r.aw = aw; r.dw = dw; r.dr = dr; r.wd = wd; r.lc = lc; r.i32 = i32; r.rq = rq; r.ra = ra;
        r.gnt = gnt; r.rv = rv; r.we = we; r.addr = addr; r.wdat = wdat; r.busy = busy; r.ovr = ovr;
        vq.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[14'h23C0] = 8'hAA;
        mem[14'h23C1] = 8'hBB;
        idle_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst.busy", cpu_busy, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.rdata", cpu_rdata, 0);
        chk("rst.rvalid", render_rvalid, 0);
        chk("rst.we", vram_we, 0);
        chk("rst.addr", vram_addr, 0);
        reset_n = 1'b1;

        exp_q.push_back({14'h2108, 8'h5A});
        exp_q.push_back({14'h2109, 8'hC3});
        exp_q.push_back({14'h3FE0, 8'h11});
        exp_q.push_back({14'h3FFF, 8'h22});
        exp_q.push_back({14'h2000, 8'h44});
        exp_q.push_back({14'h2001, 8'h77});

        //   aw dw dr wd     lc i32 rq ra          gnt rv we addr      wdat   busy ovr
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(1, 0, 0, 8'h21, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(1, 0, 0, 8'h08, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(0, 1, 0, 8'h5A, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h2108, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 1, 14'h2108, 8'h5A, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h2109, 8'h00, 0, 0);
        // render priority: five render cycles across a pending write
        add(0, 1, 0, 8'hC3, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h2109, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 14'h0100,   1, 0, 0, 14'h0100, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 14'h0101,   1, 1, 0, 14'h0101, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 14'h0102,   1, 1, 0, 14'h0102, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 14'h0103,   1, 1, 0, 14'h0103, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 14'h0104,   1, 1, 0, 14'h0104, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 1, 1, 14'h2109, 8'hC3, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h210A, 8'h00, 0, 0);
        // +32 wrap from $3FE0
        add(1, 0, 0, 8'h3F, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h210A, 8'h00, 0, 0);
        add(1, 0, 0, 8'hE0, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h210A, 8'h00, 0, 0);
        add(0, 1, 0, 8'h11, 0, 1, 0, 14'h0000,   0, 0, 0, 14'h3FE0, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 0, 14'h0000,   0, 0, 1, 14'h3FE0, 8'h11, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        // +1 wrap from $3FFF
        add(1, 0, 0, 8'h3F, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(1, 0, 0, 8'hFF, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(0, 1, 0, 8'h22, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h3FFF, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 1, 14'h3FFF, 8'h22, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        // toggle clear
        add(1, 0, 0, 8'h3F, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(1, 0, 0, 8'h20, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h0000, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h2000, 8'h00, 0, 0);
        // overrun: second write while busy is dropped
        add(0, 1, 0, 8'h44, 0, 0, 1, 14'h0200,   1, 0, 0, 14'h0200, 8'h00, 0, 0);
        add(0, 1, 0, 8'h55, 0, 0, 1, 14'h0201,   1, 1, 0, 14'h0201, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 1, 1, 14'h2000, 8'h44, 1, 1);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h2001, 8'h00, 0, 1);
        // address reload while a write is pending: new address wins
        add(0, 1, 0, 8'h77, 0, 0, 1, 14'h0300,   1, 0, 0, 14'h0300, 8'h00, 0, 1);
        add(1, 0, 0, 8'h12, 0, 0, 1, 14'h0301,   1, 1, 0, 14'h0301, 8'h00, 1, 1);
        add(1, 0, 0, 8'h34, 0, 0, 1, 14'h0302,   1, 1, 0, 14'h0302, 8'h00, 1, 1);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 1, 1, 14'h2001, 8'h77, 1, 1);
        add(0, 0, 0, 8'h00, 0, 0, 0, 14'h0000,   0, 0, 0, 14'h1234, 8'h00, 0, 1);

        foreach (vq[i]) begin
            @(negedge clk);
            cpu_addr_wr = vq[i].aw; cpu_data_wr = vq[i].dw; cpu_data_rd = vq[i].dr;
            cpu_wdata = vq[i].wd; latch_clr = vq[i].lc; inc32 = vq[i].i32;
            render_req = vq[i].rq; render_addr = vq[i].ra;
            #2;
            chk($sformatf("v%0d.gnt", i), render_gnt, vq[i].gnt);
            chk($sformatf("v%0d.rvalid", i), render_rvalid, vq[i].rv);
            chk($sformatf("v%0d.we", i), vram_we, vq[i].we);
            chk($sformatf("v%0d.addr", i), vram_addr, vq[i].addr);
            chk($sformatf("v%0d.busy", i), cpu_busy, vq[i].busy);
            chk($sformatf("v%0d.overrun", i), overrun, vq[i].ovr);
            if (vq[i].we) chk($sformatf("v%0d.wdata", i), vram_wdata, vq[i].wdat);
        end

        // Buffered reads from $23C0
        drive(1, 0, 0, 8'h23, 0, 14'h0);
        drive(1, 0, 0, 8'hC0, 0, 14'h0);
        drive(0, 0, 1, 8'h00, 0, 14'h0);
        chk("rd1.strobe_rdata", cpu_rdata, 8'h00);
        chk("rd1.strobe_busy", cpu_busy, 0);
        drive(0, 0, 0, 8'h00, 0, 14'h0);
        chk("rd1.issue_busy", cpu_busy, 1);
        chk("rd1.issue_addr", vram_addr, 14'h23C0);
        chk("rd1.issue_we", vram_we, 0);
        drive(0, 0, 0, 8'h00, 0, 14'h0);
        chk("rd1.wait_busy", cpu_busy, 1);
        drive(0, 0, 0, 8'h00, 0, 14'h0);
        chk("rd1.buf", cpu_rdata, 8'hAA);
        chk("rd1.done_busy", cpu_busy, 0);
        chk("rd1.next_addr", vram_addr, 14'h23C1);
        drive(0, 0, 1, 8'h00, 0, 14'h0);
        chk("rd2.strobe_rdata", cpu_rdata, 8'hAA);
        repeat (3) drive(0, 0, 0, 8'h00, 0, 14'h0);
        chk("rd2.buf", cpu_rdata, 8'hBB);
        chk("rd2.next_addr", vram_addr, 14'h23C2);

        // Asynchronous reset while a write is pending
        drive(0, 1, 0, 8'h99, 1, 14'h0400);
        chk("rst2.gnt", render_gnt, 1);
        drive(0, 0, 0, 8'h00, 1, 14'h0401);
        chk("rst2.pending_busy", cpu_busy, 1);
        chk("rst2.pending_overrun", overrun, 1);
        #1;
        reset_n = 1'b0;
        render_req = 1'b0;
        #1;
        chk("rst2.busy", cpu_busy, 0);
        chk("rst2.overrun", overrun, 0);
        chk("rst2.rdata", cpu_rdata, 0);
        chk("rst2.rvalid", render_rvalid, 0);
        chk("rst2.we", vram_we, 0);
        chk("rst2.addr", vram_addr, 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst2.no_write", mem[14'h23C2], 8'h00);
        reset_n = 1'b1;
        drive(0, 0, 0, 8'h00, 0, 14'h0);
        chk("rst2.after_busy", cpu_busy, 0);
        chk("rst2.after_addr", vram_addr, 0);
        chk("rst2.after_we", vram_we, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
